// File: rtl/leaf_quad_arbiter.sv
// leaf_quad_arbiter: four single-entry page slots round-robin arbitrated into one registered BFT leaf output.
module leaf_quad_arbiter #(
    parameter int DW = 49
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] din_page_0,
    input  logic [DW-1:0] din_page_1,
    input  logic [DW-1:0] din_page_2,
    input  logic [DW-1:0] din_page_3,
    output logic          ready_page_0,
    output logic          ready_page_1,
    output logic          ready_page_2,
    output logic          ready_page_3,
    input  logic [3:0]    enable,
    output logic [DW-1:0] dout_leaf,
    input  logic          leaf_ready,
    output logic [1:0]    grant_id,
    output logic [15:0]   pkt_cnt
);
    logic [DW-1:0] din [4];
    logic [DW-2:0] slot [4];
    logic [3:0] full, ready, cap, elig, clr;
    logic [1:0] rr_ptr, gnt_idx, idx;
    logic gnt_vld, out_free, load;

    assign din[0] = din_page_0;
    assign din[1] = din_page_1;
    assign din[2] = din_page_2;
    assign din[3] = din_page_3;
    // ready comes only from flops so a page never sees a combinational path through its own data
    assign ready = enable & ~full;
    assign {ready_page_3, ready_page_2, ready_page_1, ready_page_0} = ready;
    assign cap = {din[3][DW-1], din[2][DW-1], din[1][DW-1], din[0][DW-1]} & ready;
    assign elig = full & enable;
    assign out_free = ~dout_leaf[DW-1] | leaf_ready;
    assign load = out_free & gnt_vld;
    assign clr = load ? 4'b0001 << gnt_idx : 4'b0000;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_ptr;
        idx = rr_ptr;
        for (int i = 1; i <= 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full <= 4'b0000;
            for (int k = 0; k < 4; k++) slot[k] <= '0;
            dout_leaf <= '0;
            grant_id <= 2'd0;
            rr_ptr <= 2'd3;
            pkt_cnt <= 16'd0;
        end else begin
            for (int k = 0; k < 4; k++) if (cap[k]) slot[k] <= din[k][DW-2:0];
            // a slot being captured is never full, so capture and grant-clear cannot collide
            full <= (full | cap) & ~clr;
            if (load) begin
                dout_leaf <= {1'b1, slot[gnt_idx]};
                grant_id <= gnt_idx;
                rr_ptr <= gnt_idx;
            end else if (out_free) begin
                dout_leaf[DW-1] <= 1'b0;
            end
            if (dout_leaf[DW-1] && leaf_ready) pkt_cnt <= pkt_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_leaf_quad_arbiter.sv
// tb_leaf_quad_arbiter: directed stimulus with a scoreboard of expected {grant_id, dout_leaf} per accepted packet.
module tb_leaf_quad_arbiter;
    localparam int DW = 49;
    logic clk = 1'b0;
    logic reset_n;
    logic [DW-1:0] din [4];
    logic [3:0] rdy;
    logic [3:0] enable;
    logic [DW-1:0] dout_leaf;
    logic leaf_ready;
    logic [1:0] grant_id;
    logic [15:0] pkt_cnt;
    logic [DW+1:0] q [$];
    logic [DW+1:0] want;
    int n_vec = 0;
    int n_err = 0;
    bit sb_on = 1'b1;
    bit hit;

    leaf_quad_arbiter #(.DW(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .din_page_0(din[0]), .din_page_1(din[1]), .din_page_2(din[2]), .din_page_3(din[3]),
        .ready_page_0(rdy[0]), .ready_page_1(rdy[1]), .ready_page_2(rdy[2]), .ready_page_3(rdy[3]),
        .enable(enable), .dout_leaf(dout_leaf), .leaf_ready(leaf_ready),
        .grant_id(grant_id), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pk(input logic [DW-2:0] p);
        return {1'b1, p};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [1:0] g, input logic [DW-2:0] p);
        q.push_back({g, 1'b1, p});
    endtask

    // any acceptance on the coming edge must match the oldest expected packet
    task automatic tick();
        if (sb_on && dout_leaf[DW-1] && leaf_ready) begin
            want = (q.size() != 0) ? q.pop_front() : '0;
            chk("scoreboard", 64'({grant_id, dout_leaf}), 64'(want));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr_din();
        for (int k = 0; k < 4; k++) din[k] = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        clr_din();
        enable = 4'h0;
        leaf_ready = 1'b0;
        #2;
        chk("rst_dout", 64'(dout_leaf), 64'h0);
        chk("rst_grant", 64'(grant_id), 64'h0);
        chk("rst_cnt", 64'(pkt_cnt), 64'h0);
        enable = 4'hF;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        tick();
        chk("ready_after_rst", 64'(rdy), 64'hF);

        // single packet from page 2
        leaf_ready = 1'b1;
        din[2] = pk(48'h155);
        push(2'd2, 48'h155);
        tick();
        din[2] = '0;
        chk("single_ready2_low", 64'(rdy), 64'hB);
        chk("single_not_yet", 64'(dout_leaf[DW-1]), 64'h0);
        tick();
        chk("single_dout", 64'(dout_leaf), 64'(pk(48'h155)));
        chk("single_grant", 64'(grant_id), 64'h2);
        chk("single_ready2_back", 64'(rdy), 64'hF);
        tick();
        chk("single_cnt", 64'(pkt_cnt), 64'h1);
        chk("single_idle", 64'(dout_leaf[DW-1]), 64'h0);

        // round robin from reset: 0,1,2,3
        do_reset();
        for (int k = 0; k < 4; k++) begin
            din[k] = pk(48'hA00 + 48'(k));
            push(2'(k), 48'hA00 + 48'(k));
        end
        tick();
        clr_din();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_grant", 64'(grant_id), 64'(k));
            chk("rr_valid", 64'(dout_leaf[DW-1]), 64'h1);
        end
        tick();
        chk("rr_cnt", 64'(pkt_cnt), 64'h4);
        chk("rr_idle", 64'(dout_leaf[DW-1]), 64'h0);

        // backpressure on page 1
        leaf_ready = 1'b0;
        din[1] = pk(48'hB1);
        push(2'd1, 48'hB1);
        tick();
        din[1] = pk(48'hB2);
        push(2'd1, 48'hB2);
        tick();
        tick();
        din[1] = '0;
        chk("bp_hold_dout", 64'(dout_leaf), 64'(pk(48'hB1)));
        chk("bp_ready1_low", 64'(rdy[1]), 64'h0);
        tick();
        chk("bp_hold_dout2", 64'(dout_leaf), 64'(pk(48'hB1)));
        chk("bp_cnt_hold", 64'(pkt_cnt), 64'h4);
        leaf_ready = 1'b1;
        tick();
        chk("bp_no_bubble", 64'(dout_leaf), 64'(pk(48'hB2)));
        chk("bp_grant", 64'(grant_id), 64'h1);
        tick();
        chk("bp_cnt", 64'(pkt_cnt), 64'h6);

        // masking page 0 while it is valid
        enable = 4'b1110;
        din[0] = pk(48'hC0);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("mask_ready0", 64'(rdy[0]), 64'h0);
            chk("mask_no_grant", 64'(dout_leaf[DW-1]), 64'h0);
        end
        enable = 4'hF;
        push(2'd0, 48'hC0);
        tick();
        din[0] = '0;
        hit = 1'b0;
        for (int n = 0; n < 4 && !hit; n++) begin
            tick();
            hit = dout_leaf[DW-1] && grant_id == 2'd0;
        end
        chk("mask_grant0", 64'({dout_leaf, grant_id}), 64'({pk(48'hC0), 2'd0}));
        tick();

        // full slot held while its page is disabled
        din[3] = pk(48'hD3);
        tick();
        din[3] = '0;
        enable = 4'b0111;
        tick();
        chk("dis_no_grant", 64'(dout_leaf[DW-1]), 64'h0);
        chk("dis_ready3", 64'(rdy), 64'h7);
        tick();
        enable = 4'hF;
        push(2'd3, 48'hD3);
        chk("dis_still_full", 64'(rdy[3]), 64'h0);
        tick();
        chk("dis_grant3", 64'({dout_leaf, grant_id}), 64'({pk(48'hD3), 2'd3}));
        tick();
        chk("pre_reset_cnt", 64'(pkt_cnt), 64'h8);

        // reset in the middle of traffic
        leaf_ready = 1'b0;
        for (int k = 0; k < 3; k++) din[k] = pk(48'hE0 + 48'(k));
        tick();
        clr_din();
        din[3] = pk(48'hE3);
        tick();
        din[3] = '0;
        chk("mid_busy", 64'({dout_leaf[DW-1], rdy}), 64'h11);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_dout", 64'(dout_leaf), 64'h0);
        chk("mid_rst_grant", 64'(grant_id), 64'h0);
        chk("mid_rst_cnt", 64'(pkt_cnt), 64'h0);
        chk("mid_rst_ready", 64'(rdy), 64'hF);
        reset_n = 1'b1;
        leaf_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            din[k] = pk(48'hF0 + 48'(k));
            push(2'(k), 48'hF0 + 48'(k));
        end
        tick();
        clr_din();
        tick();
        chk("mid_first_win", 64'(grant_id), 64'h0);
        for (int n = 0; n < 4; n++) tick();
        chk("sb_drained", 64'(q.size()), 64'h0);

        // counter wrap under saturating traffic
        do_reset();
        sb_on = 1'b0;
        for (int k = 0; k < 4; k++) din[k] = pk(48'h5A);
        for (int n = 0; n < 70000 && pkt_cnt != 16'hFFFF; n++) tick();
        leaf_ready = 1'b0;
        clr_din();
        chk("wrap_reached", 64'(pkt_cnt), 64'hFFFF);
        chk("wrap_pending", 64'(dout_leaf[DW-1]), 64'h1);
        tick();
        chk("wrap_hold", 64'(pkt_cnt), 64'hFFFF);
        leaf_ready = 1'b1;
        tick();
        chk("wrap_zero", 64'(pkt_cnt), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/leaf_quad_arbiter.md
LEAF_QUAD_ARBITER -- requirements
Module: leaf_quad_arbiter

Interface
REQ-001 SHALL have parameter DW, default 49, meaning packet width; bit DW-1 is the valid flag, bits DW-2:0 are payload.
REQ-002 SHALL have port clk  input  1  single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports din_page_0..din_page_3  input  DW each  packet from page k; valid when bit DW-1 = 1.
REQ-005 SHALL have ports ready_page_0..ready_page_3  output  1 each  slot k can accept a packet this cycle.
REQ-006 SHALL have port enable  input  4  per-page mask; bit k = 1 allows page k to participate.
REQ-007 SHALL have port dout_leaf  output  DW  registered packet toward the BFT leaf; valid when bit DW-1 = 1.
REQ-008 SHALL have port leaf_ready  input  1  BFT leaf accepts dout_leaf this cycle.
REQ-009 SHALL have port grant_id  output  2  index of the page whose packet is in dout_leaf.
REQ-010 SHALL have port pkt_cnt  output  16  count of packets accepted by the leaf.

Function
REQ-011 SHALL hold one holding slot per page, each with a full flag and a DW-1-bit payload register.
REQ-012 SHALL drive ready_page_k = enable[k] AND NOT slot_full_k, decoded directly from flops with no dependence on din_page_k.
REQ-013 SHALL capture din_page_k into slot k and set full_k on an edge where din valid bit = 1 and ready_page_k = 1; otherwise din_page_k is ignored.
REQ-014 SHALL treat the output register as free when its valid bit = 0, or when its valid bit = 1 and leaf_ready = 1 (drain).
REQ-015 SHALL, on an edge where the output is free, grant the first page k with full_k = 1 and enable[k] = 1 in round-robin order starting at rr_ptr+1 modulo 4.
REQ-016 SHALL, on a grant, load dout_leaf with {1, slot_k payload}, set grant_id = k, set rr_ptr = k, and clear full_k, all on the same edge.
REQ-017 SHALL, when the output is free and no page is eligible, clear the dout_leaf valid bit and hold grant_id and rr_ptr.
REQ-018 SHALL, when the output is not free, hold dout_leaf and grant_id unchanged.
REQ-019 SHALL support drain and reload on the same edge, giving back-to-back output packets with no bubble.
REQ-020 SHALL give a latency of 1 edge from capture to dout_leaf valid when the output is free and no other page wins.
REQ-021 SHALL restrict any single page to at most one packet every 2 cycles, because its slot must empty before ready rises.
REQ-022 SHALL hold slot contents when enable[k] is deasserted with full_k = 1, and exclude that slot from arbitration until enable[k] returns to 1.
REQ-023 SHALL increment pkt_cnt by 1 on each edge where the dout_leaf valid bit = 1 and leaf_ready = 1.
REQ-024 SHALL wrap pkt_cnt from 16'hFFFF to 0 without a flag.
REQ-025 SHALL ignore leaf_ready while the dout_leaf valid bit = 0, with no count and no state change.

Reset
REQ-026 SHALL, while reset_n = 0 (asynchronous), set all full flags to 0, dout_leaf to 0, grant_id to 0, pkt_cnt to 0, and rr_ptr to 3, so page 0 has first priority.
REQ-027 SHALL clear any packet in flight in a slot or in dout_leaf on reset assertion mid-operation, with no partial state retained.
REQ-028 SHALL drive ready_page_k = enable[k] on the first cycle after reset release.

Verification
REQ-029 SHALL verify the single packet path: enable=4'hF, leaf_ready=1, din_page_2 valid with payload 0x155 for one cycle -> dout_leaf = {1, 0x155} one edge later, grant_id = 2, pkt_cnt = 1, ready_page_2 low for exactly 1 cycle.
REQ-030 SHALL verify round-robin order: all 4 slots full at once after reset, leaf_ready=1 -> grant_id sequence 0,1,2,3 on consecutive cycles, dout_leaf valid for 4 cycles, pkt_cnt = 4.
REQ-031 SHALL verify backpressure: leaf_ready=0 with a packet held in dout_leaf from page 1, page 1 presents a second packet -> dout_leaf unchanged, slot 1 full, ready_page_1 = 0; leaf_ready=1 -> second packet appears next edge with no bubble.
REQ-032 SHALL verify masking: enable=4'b1110, page 0 valid continuously -> ready_page_0 = 0, no grant to 0; set enable=4'hF -> page 0 granted within 4 cycles.
REQ-033 SHALL verify counter wrap: preload traffic until pkt_cnt = 16'hFFFF, accept 1 more packet -> pkt_cnt = 0.
REQ-034 SHALL verify reset mid-operation: assert reset_n=0 with 3 slots full and dout_leaf valid -> all outputs 0 immediately; after release, page 0 wins the first simultaneous contest.
